// File: rtl/mips_stim_sequencer.sv
// mips_stim_sequencer: CPU reset/run window sequencer with per-channel held interrupt requests.
// Ports: clk (clock), rst (sync, active-low), trig[N_INT] (interrupt requests),
//        int_ack[N_INT] (CPU acknowledges), cpu_rst (active-high CPU reset),
//        int_out[N_INT] (level interrupts, bit 0 = int0), running, done (sticky),
//        cycle_cnt[CW] (RUN clocks), ack_cnt[CW] (saturating acknowledged-interrupt count).
// Optional: define STIM_AUTO_INT_EN to make channel 0 self-fire every INT_PERIOD RUN clocks.
module mips_stim_sequencer #(
    parameter int N_INT = 4,
    parameter int RST_CYCLES = 4,
    parameter int RUN_CYCLES = 1000,
    parameter int CW = 16,
    parameter logic [N_INT-1:0] INT_MASK = '1
`ifdef STIM_AUTO_INT_EN
    , parameter int INT_PERIOD = 100
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_INT-1:0] trig,
    input  logic [N_INT-1:0] int_ack,
    output logic             cpu_rst,
    output logic [N_INT-1:0] int_out,
    output logic             running,
    output logic             done,
    output logic [CW-1:0]    cycle_cnt,
    output logic [CW-1:0]    ack_cnt
);
    localparam int HW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;
    state_t state, nxt;
    logic [HW-1:0] hold_cnt;
    logic [N_INT-1:0] pend, ack_q, set;
    logic [CW:0] pop, sum;
    logic [CW-1:0] ack_nxt;
    logic auto_fire;
`ifdef STIM_AUTO_INT_EN
    localparam int AW = INT_PERIOD > 2 ? $clog2(INT_PERIOD) : 1;
    logic [AW-1:0] auto_cnt;
    always_ff @(posedge clk) begin
        if (!rst)
            auto_cnt <= '0;
        else if (state == HOLD && nxt == RUN)
            auto_cnt <= AW'(INT_PERIOD - 1);
        else if (state == RUN)
            auto_cnt <= auto_fire ? AW'(INT_PERIOD - 1) : auto_cnt - 1'b1;
    end
    assign auto_fire = state == RUN && auto_cnt == '0;
`else
    assign auto_fire = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst)
            state <= HOLD;
        else
            state <= nxt;
    end
    always_comb begin
        nxt = state;
        nxt = state == HOLD ? ((RST_CYCLES == 0 || hold_cnt == HW'(RST_CYCLES - 1)) ? RUN : HOLD)
            : state == RUN  ? (cycle_cnt == CW'(RUN_CYCLES - 1) ? DONE : RUN)
            : DONE;
    end
    always_comb begin
        cpu_rst = state != RUN;
        running = state == RUN;
        done    = state == DONE;
        int_out = pend;
    end
    // Only acks against a pending request count; a same-cycle trig re-arms the channel.
    always_comb begin
        ack_q = int_ack & pend;
        set = trig & INT_MASK;
        set[0] = set[0] | (auto_fire & INT_MASK[0]);
        pop = '0;
        for (int i = 0; i < N_INT; i++)
            pop = pop + (CW + 1)'(ack_q[i]);
        sum = {1'b0, ack_cnt} + pop;
        ack_nxt = sum[CW] ? '1 : sum[CW-1:0];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt  <= '0;
            cycle_cnt <= '0;
            ack_cnt   <= '0;
            pend      <= '0;
        end else begin
            hold_cnt  <= state == HOLD ? hold_cnt + 1'b1 : hold_cnt;
            cycle_cnt <= state == RUN ? cycle_cnt + 1'b1 : cycle_cnt;
            ack_cnt   <= state == RUN ? ack_nxt : ack_cnt;
            // Pending requests are dropped on the edge that freezes the CPU.
            pend      <= (state == RUN && nxt == RUN) ? ((pend & ~ack_q) | set) : '0;
        end
    end
endmodule

// File: tb/tb_mips_stim_sequencer.sv
// tb_mips_stim_sequencer: directed self-checking bench for mips_stim_sequencer.
module tb_mips_stim_sequencer;
    logic clk, rst;
    logic [3:0] trig, int_ack;
    logic cpu_rst, running, done;
    logic [3:0] int_out;
    logic [15:0] cycle_cnt, ack_cnt;
    logic cpu_rst_m, running_m, done_m;
    logic [3:0] int_out_m;
    logic [15:0] cycle_cnt_m, ack_cnt_m;
    logic cpu_rst_s, running_s, done_s;
    logic [3:0] int_out_s;
    logic [2:0] cycle_cnt_s, ack_cnt_s;
    int n_vec = 0, n_err = 0, cyc = 0;

    mips_stim_sequencer dut (
        .clk(clk), .rst(rst), .trig(trig), .int_ack(int_ack), .cpu_rst(cpu_rst),
        .int_out(int_out), .running(running), .done(done), .cycle_cnt(cycle_cnt), .ack_cnt(ack_cnt)
    );
    mips_stim_sequencer #(.INT_MASK(4'b1101)) dut_m (
        .clk(clk), .rst(rst), .trig(trig), .int_ack(int_ack), .cpu_rst(cpu_rst_m),
        .int_out(int_out_m), .running(running_m), .done(done_m), .cycle_cnt(cycle_cnt_m), .ack_cnt(ack_cnt_m)
    );
    mips_stim_sequencer #(.CW(3), .RUN_CYCLES(7)) dut_s (
        .clk(clk), .rst(rst), .trig(trig), .int_ack(int_ack), .cpu_rst(cpu_rst_s),
        .int_out(int_out_s), .running(running_s), .done(done_s), .cycle_cnt(cycle_cnt_s), .ack_cnt(ack_cnt_s)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 0; trig = 0; int_ack = 0;
        repeat (3) tick();
        n_vec++;
        if ({cpu_rst, running, done, int_out} !== 7'b1000000) begin
            n_err++; $display("FAIL reset_outs got %b want 1000000", {cpu_rst, running, done, int_out});
        end
        n_vec++;
        if (cycle_cnt !== 0 || ack_cnt !== 0) begin
            n_err++; $display("FAIL reset_cnts got %0d/%0d want 0/0", cycle_cnt, ack_cnt);
        end
        rst = 1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_vec++;
            if (cpu_rst !== (k < 4) || running !== (k == 4)) begin
                n_err++; $display("FAIL hold_edge%0d got cpu_rst=%b running=%b want %b/%b", k, cpu_rst, running, k < 4, k == 4);
            end
        end
        cyc = 0;
    endtask

    task automatic test_int();
        trig = 4'b0101; tick(); trig = 0;
        n_vec++;
        if (int_out !== 4'b0101) begin
            n_err++; $display("FAIL int_set got %b want 0101", int_out);
        end
        n_vec++;
        if (int_out_m !== 4'b0101) begin
            n_err++; $display("FAIL int_set_masked got %b want 0101", int_out_m);
        end
        int_ack = 4'b0001; tick(); int_ack = 0;
        n_vec++;
        if (int_out !== 4'b0100 || ack_cnt !== 1) begin
            n_err++; $display("FAIL ack0 got %b/%0d want 0100/1", int_out, ack_cnt);
        end
        int_ack = 4'b0100; tick(); int_ack = 0;
        n_vec++;
        if (int_out !== 4'b0000 || ack_cnt !== 2) begin
            n_err++; $display("FAIL ack2 got %b/%0d want 0000/2", int_out, ack_cnt);
        end
        int_ack = 4'b1111; tick(); int_ack = 0;
        n_vec++;
        if (ack_cnt !== 2) begin
            n_err++; $display("FAIL stray_ack got %0d want 2", ack_cnt);
        end
        trig = 4'b1011; tick(); trig = 0;
        int_ack = 4'b1011; tick(); int_ack = 0;
        n_vec++;
        if (int_out !== 4'b0000 || ack_cnt !== 5) begin
            n_err++; $display("FAIL multi_ack got %b/%0d want 0000/5", int_out, ack_cnt);
        end
        n_vec++;
        if (cycle_cnt !== 16'(cyc)) begin
            n_err++; $display("FAIL cycle_track got %0d want %0d", cycle_cnt, cyc);
        end
    endtask

    task automatic test_same_cycle();
        trig = 4'b0010; tick();
        n_vec++;
        if (int_out !== 4'b0010 || int_out_m !== 4'b0000) begin
            n_err++; $display("FAIL trig1 got %b/%b want 0010/0000", int_out, int_out_m);
        end
        int_ack = 4'b0010; tick();
        n_vec++;
        if (int_out !== 4'b0010 || ack_cnt !== 6 || int_out_m !== 4'b0000) begin
            n_err++; $display("FAIL same_cycle got %b/%0d/%b want 0010/6/0000", int_out, ack_cnt, int_out_m);
        end
        trig = 0; tick(); int_ack = 0;
        n_vec++;
        if (int_out !== 4'b0000 || ack_cnt !== 7) begin
            n_err++; $display("FAIL ack_after got %b/%0d want 0000/7", int_out, ack_cnt);
        end
    endtask

    task automatic test_abort();
        while (cyc < 499) tick();
        trig = 4'b1000; tick(); trig = 0;
        n_vec++;
        if (int_out !== 4'b1000 || cycle_cnt !== 500) begin
            n_err++; $display("FAIL pre_abort got %b/%0d want 1000/500", int_out, cycle_cnt);
        end
        rst = 0; tick();
        n_vec++;
        if (int_out !== 0 || cycle_cnt !== 0 || cpu_rst !== 1 || running !== 0 || ack_cnt !== 0) begin
            n_err++; $display("FAIL abort got int=%b cyc=%0d cpu_rst=%b run=%b ack=%0d want 0/0/1/0/0",
                int_out, cycle_cnt, cpu_rst, running, ack_cnt);
        end
        rst = 1;
        repeat (4) tick();
        n_vec++;
        if (running !== 1 || cpu_rst !== 0 || cycle_cnt !== 0) begin
            n_err++; $display("FAIL rerun got run=%b cpu_rst=%b cyc=%0d want 1/0/0", running, cpu_rst, cycle_cnt);
        end
        cyc = 0;
    endtask

    task automatic test_saturate();
        trig = 4'b1111; tick();
        int_ack = 4'b1111; tick(); tick();
        n_vec++;
        if (ack_cnt_s !== 3'd7 || ack_cnt !== 8) begin
            n_err++; $display("FAIL sat_hit got %0d/%0d want 7/8", ack_cnt_s, ack_cnt);
        end
        trig = 0; tick(); int_ack = 0;
        n_vec++;
        if (ack_cnt_s !== 3'd7 || ack_cnt !== 12 || int_out !== 0) begin
            n_err++; $display("FAIL sat_hold got %0d/%0d/%b want 7/12/0000", ack_cnt_s, ack_cnt, int_out);
        end
    endtask

    task automatic test_done();
        while (cyc < 998) tick();
        trig = 4'b0001; tick(); trig = 0;
        n_vec++;
        if (int_out !== 4'b0001 || running !== 1 || done !== 0 || cycle_cnt !== 999) begin
            n_err++; $display("FAIL last_run got %b/%b/%b/%0d want 0001/1/0/999", int_out, running, done, cycle_cnt);
        end
        tick();
        n_vec++;
        if (done !== 1 || cpu_rst !== 1 || running !== 0 || cycle_cnt !== 1000 || int_out !== 0) begin
            n_err++; $display("FAIL done_entry got done=%b cpu_rst=%b run=%b cyc=%0d int=%b want 1/1/0/1000/0000",
                done, cpu_rst, running, cycle_cnt, int_out);
        end
        trig = 4'b1111; int_ack = 4'b1111;
        repeat (5) tick();
        trig = 0; int_ack = 0;
        n_vec++;
        if (done !== 1 || cycle_cnt !== 1000 || int_out !== 0 || ack_cnt !== 12) begin
            n_err++; $display("FAIL done_stable got done=%b cyc=%0d int=%b ack=%0d want 1/1000/0000/12",
                done, cycle_cnt, int_out, ack_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_int();
        test_same_cycle();
        test_abort();
        test_saturate();
        test_done();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got running bench want finished");
        $fatal(1);
    end
endmodule
